// File: rtl/imu_frame_pkg.sv
// imu_frame_pkg: shared states, frame geometry and flag bit positions for imu_frame_loader.
package imu_frame_pkg;
   typedef enum logic [2:0] {HUNT, FLAGS, DATA, CHK, EMIT} state_t;
   localparam int FRAME_DATA_BYTES = 12;
   localparam int ROLL = 0;
   localparam int PITCH = 1;
   localparam int YAW = 2;
endpackage

// File: rtl/imu_frame_loader_dt_timer.sv
// dt_timer: free-running prescaler plus saturating tick counter, restarted by i_tick_clear.
module dt_timer #(
   parameter int PRESCALE = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_tick_clear,
   output logic [7:0] o_dt
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   logic [PW-1:0] r_pre;
   logic [7:0]    r_dt;
   logic          w_tick;
   assign w_tick = (r_pre == PMAX);
   assign o_dt = r_dt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre <= '0;
         r_dt  <= '0;
      end else begin
         r_pre <= w_tick ? '0 : r_pre + 1'b1;
         // a tick landing on the clear cycle belongs to the next interval
         if (i_tick_clear) r_dt <= {7'd0, w_tick};
         else if (w_tick && r_dt != 8'hFF) r_dt <= r_dt + 8'd1;
      end
   end
endmodule

// File: rtl/imu_frame_loader.sv
// imu_frame_loader: assembles framed IMU samples from a byte stream for kalman_alu.
// Define IMU_FRAME_CHKSUM_EN to require and validate the trailing checksum byte.
module imu_frame_loader
   import imu_frame_pkg::*;
#(
   parameter int          PRESCALE  = 64,
   parameter int          TIMEOUT   = 1024,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_byte_in,
   input  logic        i_byte_valid,
   output logic [47:0] o_gyro_data,
   output logic [15:0] o_roll_data,
   output logic [15:0] o_pitch_data,
   output logic [15:0] o_yaw_data,
   output logic [7:0]  o_dt_out,
   output logic        o_load_gyro,
   output logic        o_roll_en,
   output logic        o_pitch_en,
   output logic        o_yaw_en,
   output logic        o_frame_err,
   output logic        o_busy
);
   localparam int GW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam logic [GW-1:0] GMAX = GW'(TIMEOUT - 1);
   localparam logic [3:0] LAST = 4'(FRAME_DATA_BYTES - 1);
   state_t        r_state, w_next;
   logic [3:0]    r_idx;
   logic [GW-1:0] r_gap;
   logic [2:0]    r_flags;
   logic [7:0]    r_buf [FRAME_DATA_BYTES];
   logic [7:0]    w_dt;
   logic          w_err, w_emit;
`ifdef IMU_FRAME_CHKSUM_EN
   logic [7:0]    r_sum;
`endif
   assign w_emit = (r_state == EMIT);
   assign o_busy = (r_state != HUNT);
   dt_timer #(.PRESCALE(PRESCALE)) u_dt (
      .clk          (clk),
      .rst          (rst),
      .i_tick_clear (w_emit),
      .o_dt         (w_dt)
   );
   always_ff @(posedge clk) begin
      if (rst) r_state <= HUNT;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      w_err = 1'b0;
      case (r_state)
         FLAGS: if (i_byte_valid) begin
            w_err = |i_byte_in[7:3];
            w_next = w_err ? HUNT : DATA;
         end
`ifdef IMU_FRAME_CHKSUM_EN
         DATA: if (i_byte_valid && r_idx == LAST) w_next = CHK;
         CHK: if (i_byte_valid) begin
            w_err = (i_byte_in != r_sum);
            w_next = w_err ? HUNT : EMIT;
         end
`else
         DATA: if (i_byte_valid && r_idx == LAST) w_next = EMIT;
`endif
         default: w_next = (i_byte_valid && i_byte_in == SYNC_BYTE) ? FLAGS : HUNT;
      endcase
      // the gap counter only runs inside a frame; EMIT is treated like HUNT
      if (r_state != HUNT && r_state != EMIT && !i_byte_valid && r_gap == GMAX) begin
         w_next = HUNT;
         w_err = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= '0;
         r_gap        <= '0;
         r_flags      <= '0;
`ifdef IMU_FRAME_CHKSUM_EN
         r_sum        <= '0;
`endif
         o_gyro_data  <= '0;
         o_roll_data  <= '0;
         o_pitch_data <= '0;
         o_yaw_data   <= '0;
         o_dt_out     <= '0;
         o_load_gyro  <= 1'b0;
         o_roll_en    <= 1'b0;
         o_pitch_en   <= 1'b0;
         o_yaw_en     <= 1'b0;
         o_frame_err  <= 1'b0;
      end else begin
         r_gap       <= (i_byte_valid || r_state == HUNT || w_emit) ? '0 : r_gap + 1'b1;
         o_frame_err <= w_err;
         o_load_gyro <= w_emit;
         o_roll_en   <= w_emit & r_flags[ROLL];
         o_pitch_en  <= w_emit & r_flags[PITCH];
         o_yaw_en    <= w_emit & r_flags[YAW];
         if (i_byte_valid && r_state == FLAGS) begin
            r_flags <= i_byte_in[2:0];
            r_idx   <= '0;
`ifdef IMU_FRAME_CHKSUM_EN
            r_sum   <= i_byte_in;
`endif
         end
         if (i_byte_valid && r_state == DATA) begin
            r_buf[r_idx] <= i_byte_in;
            r_idx        <= r_idx + 1'b1;
`ifdef IMU_FRAME_CHKSUM_EN
            r_sum        <= r_sum + i_byte_in;
`endif
         end
         if (w_emit) begin
            o_gyro_data  <= {r_buf[0], r_buf[1], r_buf[2], r_buf[3], r_buf[4], r_buf[5]};
            o_roll_data  <= {r_buf[6], r_buf[7]};
            o_pitch_data <= {r_buf[8], r_buf[9]};
            o_yaw_data   <= {r_buf[10], r_buf[11]};
            o_dt_out     <= w_dt;
         end
      end
   end
endmodule
